// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bundle: command handshake, status and line controls.
// Master side issues commands and supplies raw lines; slave is the transmitter.
interface ps2_host_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_start, tx_data,
    output ps2_clk_in, ps2_data_in,
    input  ps2_clk_oe, ps2_data_oe,
    input  busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_start, tx_data,
    input  ps2_clk_in, ps2_data_in,
    output ps2_clk_oe, ps2_data_oe,
    output busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, serialise on
// device clock falls, check ACK; drives open-drain lines via pull-low enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic clk,
  input  logic rst,
  ps2_host_tx_if.slave bus
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic          done_q, done_d;
  logic          to_pls_q, to_pls_d;
  logic          ack_err_q, ack_err_d;

  logic [1:0]    clk_s_q;
  logic [1:0]    dat_s_q;
  logic          clk_prev_q;

  logic          clk_sync;
  logic          dat_sync;
  logic          fall;
  logic          active;
  logic          pull_clk;
  logic          pull_dat;

  assign clk_sync = clk_s_q[1];
  assign dat_sync = dat_s_q[1];
  assign fall     = clk_prev_q & ~clk_sync;
  assign active   = (state_q == S_RTS) || (state_q == S_SEND) ||
                    (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_q    <= '1;
      bit_cnt_q  <= '0;
      inh_q      <= '0;
      to_q       <= '0;
      done_q     <= 1'b0;
      to_pls_q   <= 1'b0;
      ack_err_q  <= 1'b0;
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_q      <= inh_d;
      to_q       <= to_d;
      done_q     <= done_d;
      to_pls_q   <= to_pls_d;
      ack_err_q  <= ack_err_d;
      clk_s_q    <= {clk_s_q[0], bus.ps2_clk_in};
      dat_s_q    <= {dat_s_q[0], bus.ps2_data_in};
      clk_prev_q <= clk_sync;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_d     = inh_q;
    to_d      = to_q;
    done_d    = 1'b0;
    to_pls_d  = 1'b0;
    ack_err_d = ack_err_q;
    pull_clk  = 1'b0;
    pull_dat  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          frame_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
          inh_d     = '0;
          ack_err_d = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        pull_clk = 1'b1;
        inh_d    = inh_q + IW'(1);
        // start bit goes low while the clock is still held
        if (inh_q == INH_LAST) begin
          pull_dat = 1'b1;
          to_d     = '0;
          state_d  = S_RTS;
        end
      end
      S_RTS: begin
        pull_dat = 1'b1;
        if (fall) begin
          bit_cnt_d = 4'd1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        pull_dat = ~frame_q[0];
        if (fall) begin
          frame_d   = {1'b1, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_err_d = dat_sync;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (active) begin
      to_d = to_q + TW'(1);
      // abort wins over any same-cycle fall or completion
      if (to_q == TO_LAST) begin
        state_d   = S_IDLE;
        to_pls_d  = 1'b1;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
      end
    end
  end

  assign bus.ps2_clk_oe  = pull_clk;
  assign bus.ps2_data_oe = pull_dat;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.timeout     = to_pls_q;

endmodule
